// File: rtl/instr_issue_buffer.sv
// rtl/instr_issue_buffer.sv - dual-lane instruction issue buffer ahead of control_unit
module instr_issue_buffer #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_valid,
  input  logic [31:0]              fetch_instr,
  output logic                     fetch_ready,
  input  logic                     flush,
  input  logic                     mode,
  input  logic                     dec_ready,
  output logic                     issue_validA,
  output logic                     issue_validB,
  output logic [31:0]              instrA,
  output logic [31:0]              instrB,
  output logic [6:0]               opcodeA,
  output logic [6:0]               opcodeB,
  output logic [2:0]               funct3A,
  output logic [2:0]               funct3B,
  output logic [6:0]               funct7A,
  output logic [6:0]               funct7B,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  logic [31:0]   head;
  logic [31:0]   nxt;
  logic          push;
  logic          out_free;
  logic          head_cf;
  logic [1:0]    pop;
  logic          next_valid_a;
  logic          next_valid_b;

  // Branches and JALR redirect fetch, so they never share an issue slot.
  function automatic logic is_ctrl_flow(input logic [31:0] ins);
    return (ins[6:0] == 7'b1100011) || (ins[6:0] == 7'b1100111);
  endfunction

  assign count       = cnt;
  assign fetch_ready = (cnt != CW'(DEPTH));
  assign push        = fetch_valid && fetch_ready && !flush;
  assign head        = mem[rd_ptr];
  assign nxt         = mem[rd_ptr + PW'(1)];
  assign head_cf     = is_ctrl_flow(head);
  assign out_free    = !(issue_validA || issue_validB) || dec_ready;

  assign opcodeA = instrA[6:0];
  assign opcodeB = instrB[6:0];
  assign funct3A = instrA[14:12];
  assign funct3B = instrB[14:12];
  assign funct7A = instrA[31:25];
  assign funct7B = instrB[31:25];

  // Pop decision: how many entries leave the FIFO and which lanes become valid.
  always_comb begin
    pop          = 2'd0;
    next_valid_a = 1'b0;
    next_valid_b = 1'b0;
    if (out_free && (cnt != '0)) begin
      if (head_cf || ((cnt == CW'(1)) && !mode)) begin
        pop          = 2'd1;
        next_valid_a = 1'b1;
      end else if (cnt != CW'(1)) begin
        pop          = 2'd2;
        next_valid_a = 1'b1;
        next_valid_b = 1'b1;
      end
    end
  end

  // FIFO storage; entries are not reset, occupancy is tracked by cnt.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= fetch_instr;
    end
  end

  // Pointers, occupancy and the registered issue pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      issue_validA <= 1'b0;
      issue_validB <= 1'b0;
      instrA       <= NOP_INSTR;
      instrB       <= NOP_INSTR;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      issue_validA <= 1'b0;
      issue_validB <= 1'b0;
      instrA       <= NOP_INSTR;
      instrB       <= NOP_INSTR;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr <= rd_ptr + PW'(pop);
      cnt    <= cnt + CW'(push) - CW'(pop);
      if (out_free) begin
        issue_validA <= next_valid_a;
        issue_validB <= next_valid_b;
        instrA       <= next_valid_a ? head : NOP_INSTR;
        instrB       <= next_valid_b ? nxt  : NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_instr_issue_buffer.sv
// tb/tb_instr_issue_buffer.sv - scoreboard bench for instr_issue_buffer
module tb_instr_issue_buffer;

  localparam int          DEPTH = 8;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_ready;
  logic        flush;
  logic        mode;
  logic        dec_ready;
  logic        issue_validA;
  logic        issue_validB;
  logic [31:0] instrA;
  logic [31:0] instrB;
  logic [6:0]  opcodeA;
  logic [6:0]  opcodeB;
  logic [2:0]  funct3A;
  logic [2:0]  funct3B;
  logic [6:0]  funct7A;
  logic [6:0]  funct7B;
  logic [3:0]  count;

  instr_issue_buffer #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_ready(fetch_ready),
    .flush(flush), .mode(mode), .dec_ready(dec_ready),
    .issue_validA(issue_validA), .issue_validB(issue_validB),
    .instrA(instrA), .instrB(instrB),
    .opcodeA(opcodeA), .opcodeB(opcodeB),
    .funct3A(funct3A), .funct3B(funct3B),
    .funct7A(funct7A), .funct7B(funct7B),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        vb;
  } pair_t;

  int          total = 0;
  int          bad   = 0;
  logic        mon_en = 1'b0;
  logic [31:0] mq[$];
  pair_t       expq[$];
  logic        m_valid = 1'b0;
  int          seq = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic is_cf(input logic [31:0] ins);
    return (ins[6:0] == 7'b1100011) || (ins[6:0] == 7'b1100111);
  endfunction

  // Reference: queue of buffered words, issue held pair, expected issue sequence.
  task automatic model_edge(input logic fv, input logic [31:0] fi, input logic fl,
                            input logic md, input logic dr);
    pair_t p;
    int    n;
    logic  can_push;
    if (fl) begin
      mq.delete();
      expq.delete();
      m_valid = 1'b0;
      return;
    end
    n        = mq.size();
    can_push = (n != DEPTH);
    if (!m_valid || dr) begin
      if (n == 0 || (n == 1 && md && !is_cf(mq[0]))) begin
        m_valid = 1'b0;
      end else if (is_cf(mq[0]) || n == 1) begin
        p.a = mq.pop_front(); p.b = NOP; p.vb = 1'b0;
        expq.push_back(p);
        m_valid = 1'b1;
      end else begin
        p.a = mq.pop_front(); p.b = mq.pop_front(); p.vb = 1'b1;
        expq.push_back(p);
        m_valid = 1'b1;
      end
    end
    if (fv && can_push) mq.push_back(fi);
  endtask

  task automatic step(input logic fv, input logic [31:0] fi, input logic fl,
                      input logic md, input logic dr);
    fetch_valid = fv; fetch_instr = fi; flush = fl; mode = md; dec_ready = dr;
    @(posedge clk);
    model_edge(fv, fi, fl, md, dr);
    #1;
  endtask

  function automatic logic [31:0] next_word();
    logic [31:0] w;
    seq++;
    w = {7'(seq), 25'(seq * 37)};
    case ($urandom_range(0, 7))
      0:       w[6:0] = 7'b1100011;
      1:       w[6:0] = 7'b1100111;
      2:       w[6:0] = 7'b0010011;
      default: w[6:0] = 7'b0110011;
    endcase
    return w;
  endfunction

  // Monitor: compares each consumed issue pair against the scoreboard.
  always @(negedge clk) begin
    pair_t e;
    logic [31:0] ea;
    logic [31:0] eb;
    if (rst_n && mon_en) begin
      check("count", 32'(count), 32'(mq.size()));
      check("fetch_ready", 32'(fetch_ready), 32'(mq.size() != DEPTH));
      if (issue_validA) begin
        if (dec_ready && !flush) begin
          if (expq.size() == 0) begin
            check("unexpected_issue", 32'(issue_validA), 32'd0);
          end else begin
            e  = expq.pop_front();
            ea = e.a;
            eb = e.b;
            check("instrA", instrA, ea);
            check("validB", 32'(issue_validB), 32'(e.vb));
            check("instrB", instrB, eb);
            check("opcodeA", 32'(opcodeA), 32'(ea[6:0]));
            check("funct3A", 32'(funct3A), 32'(ea[14:12]));
            check("funct7A", 32'(funct7A), 32'(ea[31:25]));
            check("opcodeB", 32'(opcodeB), 32'(eb[6:0]));
            check("funct3B", 32'(funct3B), 32'(eb[14:12]));
            check("funct7B", 32'(funct7B), 32'(eb[31:25]));
          end
        end
      end else begin
        check("idle_validB", 32'(issue_validB), 32'd0);
        check("idle_instrA", instrA, NOP);
        check("idle_opcodeA", 32'(opcodeA), 32'h13);
        check("idle_funct7B", 32'(funct7B), 32'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    fetch_valid = 1'b0; fetch_instr = '0; flush = 1'b0; mode = 1'b0; dec_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_validA", 32'(issue_validA), 32'd0);
    check("rst_instrA", instrA, NOP);
    check("rst_instrB", instrB, NOP);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    check("rst_fetch_ready", 32'(fetch_ready), 32'd1);

    // split pair: add then sub
    step(1, 32'h00208033, 0, 0, 1);
    step(1, 32'h40208033, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // split: branch issues alone, add follows alone
    step(1, 32'h00208063, 0, 0, 1);
    step(1, 32'h00208033, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

    // unified: lone addi waits for a partner
    step(1, 32'h00100093, 0, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1);
    check("unified_wait_count", 32'(count), 32'd1);
    check("unified_wait_validA", 32'(issue_validA), 32'd0);
    step(1, 32'h00208033, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);

    // fill to full with a held pair, then release with push asserted
    step(1, {7'd1, 18'd0, 7'b0110011}, 0, 1, 0);
    step(1, {7'd2, 18'd0, 7'b0110011}, 0, 1, 0);
    for (int i = 0; i < 12; i++) step(1, {7'(i + 3), 18'd0, 7'b0110011}, 0, 1, 0);
    check("full_fetch_ready", 32'(fetch_ready), 32'd0);
    check("full_count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) step(1, {7'(i + 20), 18'd0, 7'b0110011}, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);

    // flush with a same-cycle push while five entries are queued
    for (int i = 0; i < 6; i++) step(1, {7'(i + 40), 18'd0, 7'b0110011}, 0, 0, 0);
    step(1, 32'hDEAD0033, 1, 0, 0);
    check("flush_count", 32'(count), 32'd0);
    check("flush_validA", 32'(issue_validA), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

    // asynchronous reset mid-stream with entries queued
    for (int i = 0; i < 4; i++) step(1, {7'(i + 60), 18'd0, 7'b0110011}, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    mq.delete(); expq.delete(); m_valid = 1'b0;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_validA", 32'(issue_validA), 32'd0);
    check("mid_rst_instrA", instrA, NOP);
    check("mid_rst_fetch_ready", 32'(fetch_ready), 32'd1);
    fetch_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, next_word(), $urandom_range(0, 99) < 2,
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6);
    end

    for (int i = 0; i < 30; i++) step(0, 0, 0, 0, 1);
    check("drain_expq_empty", 32'(expq.size()), 32'd0);
    check("drain_count", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_issue_buffer.md
Name: instr_issue_buffer

Overview:
Dual-lane instruction buffer directly upstream of control_unit. It accepts one 32-bit instruction per cycle from fetch into a circular FIFO, then issues up to two instructions per cycle on lanes A and B. Outputs are registered, and opcode/funct3/funct7 for each lane are pre-sliced to feed control_unit. Issue follows the same `mode` input as control_unit: unified is lockstep pairs, split is independent lanes.

Parameters:
DEPTH, 8, FIFO entries; power of two, ≥4
NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) driven on an invalid lane

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
fetch_valid  in  1  fetch presents an instruction
fetch_instr  in  32  instruction word
fetch_ready  out  1  buffer can accept; push when fetch_valid && fetch_ready
flush  in  1  synchronous discard of all buffered and issued-but-unconsumed instructions
mode  in  1  1 = unified (lockstep pair), 0 = split
dec_ready  in  1  decode consumes the current issue pair this cycle
issue_validA  out  1  lane A holds a real instruction
issue_validB  out  1  lane B holds a real instruction
instrA  out  32  lane A instruction (NOP_INSTR when invalid)
instrB  out  32  lane B instruction (NOP_INSTR when invalid)
opcodeA, opcodeB  out  7  instr[6:0] of each lane
funct3A, funct3B  out  3  instr[14:12]
funct7A, funct7B  out  7  instr[31:25]
count  out  $clog2(DEPTH)+1  FIFO occupancy, excluding the output register

Behaviour:
- Reset (async, rst_n=0): count=0, rd/wr pointers=0, issue_validA/B=0, instrA/B=NOP_INSTR, fetch_ready=1 after release.
- FIFO:
  - Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
  - fetch_ready = (count != DEPTH). Computed from registered count only; a same-cycle pop does not raise it.
  - Push and pop in the same cycle are legal: count += push − popped (popped ∈ {0,1,2}).
- Output register is "free" when !(issue_validA||issue_validB) or dec_ready=1. Pop decisions are made only when it is free. Otherwise outputs hold stable and no pop occurs.
- Control-flow instruction: opcode 1100011 (branch) or 1100111 (JALR). It always issues alone on lane A with lane B bubbled (validB=0, instrB=NOP_INSTR).
- Pop rules when free (H = head, N = head+1):
  - count=0: both lanes invalid.
  - H is control-flow: pop 1 → A=H, B bubble (both modes).
  - split, count=1: pop 1 → A=H, B bubble.
  - split, count≥2, H not control-flow: pop 2 → A=H, B=N. N may itself be a branch.
  - unified, count=1, H not control-flow: pop 0 and wait for a partner; outputs go invalid.
  - unified, count≥2, H not control-flow: pop 2 → A=H, B=N.
- Lane A is always older than lane B; order is strictly preserved.
- Latency: an instruction accepted on edge k into an empty buffer with a free output register is visible on lane A after edge k+1. No push-to-output bypass.
- flush=1 at an edge:
  - count=0, pointers=0, issue_validA/B=0, instrA/B=NOP_INSTR.
  - Any same-cycle push is dropped.
  - Flush overrides dec_ready.
- Mode change: takes effect at the next pop decision. The held output pair is unaffected.
- Slices opcode/funct3/funct7 are taken from the registered instrA/B. Invalid lanes therefore show NOP fields (opcode 0010011, funct3 000, funct7 0000000).

Test Plan:
1. Reset mid-stream with 3 entries queued → count=0, validA/B=0, instrA=32'h00000013 immediately (asynchronous), fetch_ready=1.
2. Split, dec_ready=1: push 0x00208033 (add), then 0x40208033 (sub) → pair issues A=add, B=sub; opcodeA=opcodeB=0110011, funct7B=0100000.
3. Split: push beq 0x00208063 then add → first pop A=beq, validB=0; next pop A=add alone.
4. Unified: push a single addi 0x00100093, hold fetch_valid=0 for 5 cycles → validA stays 0, count=1. Then push add → A=addi, B=add.
5. dec_ready=0 with a pair held: push until count=8 → fetch_ready=0, outputs stable. Raise dec_ready with push asserted → pop 2 and count 8→6; push accepted only the cycle after fetch_ready returns to 1. Pointer wrap yields correct order across 12 instructions.
6. flush asserted together with fetch_valid=1 and count=5 → next cycle count=0, both lanes invalid, the pushed word is never issued.
